// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher / pulse catcher pair:
// FSM state encoding and constant helpers.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL_HI = 2'd1,
    ACTIVE  = 2'd2,
    QUAL_LO = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser with synchronous active-high clear.
module sync_bit
  import pulse_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (clr) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_catcher.sv
// Receive side of the pulse stretcher: synchronise, qualify high/low widths,
// emit one pulse_out per pulse and count. PULSE_TIMEOUT_EN adds a stuck-high flag.
module pulse_catcher
  import pulse_pkg::*;
#(
  parameter int N           = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2,
  parameter int MIN_LOW     = 2,
  parameter int MAX_HIGH    = 256
) (
  input  logic         rd_clk,
  input  logic         reset,
  input  logic         pulse_in,
  output logic         pulse_out,
  output logic         busy,
  output logic [N-1:0] count,
  output logic         stuck
);

  localparam int QW = clog2(max3(MIN_HIGH, MIN_LOW, MAX_HIGH)) + 1;
  localparam logic [QW-1:0] MH = QW'(MIN_HIGH);
  localparam logic [QW-1:0] ML = QW'(MIN_LOW);

  logic          s;
  state_e        state_q, state_d;
  logic [QW-1:0] q_q, q_d, q_inc;
  logic          fire;
  logic          pulse_out_q, pulse_out_d;
  logic          busy_q, busy_d;
  logic [N-1:0]  count_q, count_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (rd_clk),
    .clr (reset),
    .d   (pulse_in),
    .q   (s)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    fire    = 1'b0;
    q_inc   = q_q + QW'(1);
    case (state_q)
      IDLE: if (s) begin
        if (MIN_HIGH == 1) begin
          state_d = ACTIVE;
          q_d     = '0;
          fire    = 1'b1;
        end else begin
          state_d = QUAL_HI;
          q_d     = QW'(1);
        end
      end
      QUAL_HI: begin
        if (!s) begin
          state_d = IDLE;
          q_d     = '0;
        end else if (q_inc >= MH) begin
          state_d = ACTIVE;
          q_d     = '0;
          fire    = 1'b1;
        end else begin
          q_d = q_inc;
        end
      end
      ACTIVE: begin
        if (!s) begin
          if (MIN_LOW == 1) begin
            state_d = IDLE;
            q_d     = '0;
          end else begin
            state_d = QUAL_LO;
            q_d     = QW'(1);
          end
        end
`ifdef PULSE_TIMEOUT_EN
        // saturate so a long stuck-high never wraps the counter
        else if (q_q < QW'(MAX_HIGH)) begin
          q_d = q_inc;
        end
`endif
      end
      QUAL_LO: begin
        if (s) begin
          state_d = ACTIVE;
          q_d     = '0;
        end else if (q_inc >= ML) begin
          state_d = IDLE;
          q_d     = '0;
        end else begin
          q_d = q_inc;
        end
      end
      default: begin
        state_d = IDLE;
        q_d     = '0;
      end
    endcase
    pulse_out_d = fire;
    busy_d      = (state_d != IDLE);
    count_d     = fire ? count_q + N'(1) : count_q;
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      q_q         <= '0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      pulse_out_q <= pulse_out_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
    end
  end

`ifdef PULSE_TIMEOUT_EN
  logic stuck_q, stuck_d;

  always_comb begin
    stuck_d = stuck_q | ((state_q == ACTIVE) && s && (q_inc >= QW'(MAX_HIGH)));
  end

  always_ff @(posedge rd_clk) begin
    if (reset) stuck_q <= 1'b0;
    else       stuck_q <= stuck_d;
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;
  assign count     = count_q;

endmodule

// File: tb/tb_pulse_catcher.sv
// Scoreboard bench for pulse_catcher: expected pulses are queued when driven
// and matched against pulse_out (cycle and count) by a negedge monitor.
module tb_pulse_catcher;

  localparam int N  = 4;
  localparam int MX = 8;
  localparam int LAT = 4;  // negedge-drive to visible pulse_out with defaults

  logic         rd_clk = 1'b0;
  logic         reset;
  logic         pulse_in;
  logic         pulse_out;
  logic         busy;
  logic [N-1:0] count;
  logic         stuck;

  typedef struct {
    int           cyc;
    logic [N-1:0] cnt;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;
  int           n_fire = 0;
  logic [N-1:0] exp_cnt = '0;

  pulse_catcher #(.N(N), .SYNC_STAGES(2), .MIN_HIGH(2), .MIN_LOW(2), .MAX_HIGH(MX)) dut (
    .rd_clk    (rd_clk),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .pulse_out (pulse_out),
    .busy      (busy),
    .count     (count),
    .stuck     (stuck)
  );

  always #5 rd_clk = ~rd_clk;
  always @(posedge rd_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  // Called at a negedge right as pulse_in is raised for a pulse that must qualify.
  task automatic push();
    exp_t e;
    exp_cnt = exp_cnt + 1'b1;
    e.cyc = cyc + LAT;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  always @(negedge rd_clk) begin
    if (pulse_out !== 1'b0) begin
      n_fire++;
      if (sb.size() == 0) begin
        chk("unexp_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cyc", cyc, e.cyc);
        chk("pulse_cnt", count, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    reset    = 1'b1;
    pulse_in = 1'b1;

    // reset held with pulse_in high: nothing comes out
    repeat (3) begin
      @(negedge rd_clk);
      chk("rst_pout", pulse_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", count, 0);
      chk("rst_stuck", stuck, 0);
    end
    reset = 1'b0;
    push();
    repeat (4) @(negedge rd_clk);
    pulse_in = 1'b0;
    repeat (6) @(negedge rd_clk);
    chk("post_rst_cnt", count, 1);

    // plain 4-cycle pulse, busy drops 2 edges after s falls
    pulse_in = 1'b1;
    push();
    repeat (4) @(negedge rd_clk);
    pulse_in = 1'b0;
    repeat (3) @(negedge rd_clk);
    chk("busy_tail", busy, 1);
    @(negedge rd_clk);
    chk("busy_fall", busy, 0);
    repeat (3) @(negedge rd_clk);

    // one-cycle glitch is rejected
    pulse_in = 1'b1;
    @(negedge rd_clk);
    chk("glitch_busy_hi", busy, 0);
    pulse_in = 1'b0;
    repeat (6) @(negedge rd_clk);
    chk("glitch_cnt", count, 2);
    chk("glitch_busy", busy, 0);

    // a 1-cycle dip inside a pulse merges into it
    pulse_in = 1'b1;
    push();
    repeat (5) @(negedge rd_clk);
    pulse_in = 1'b0;
    @(negedge rd_clk);
    pulse_in = 1'b1;
    repeat (5) @(negedge rd_clk);
    pulse_in = 1'b0;
    repeat (6) @(negedge rd_clk);
    chk("dip_cnt", count, 3);
    chk("dip_busy", busy, 0);

    // wrap: 17 pulses on a 4-bit count
    reset = 1'b1;
    repeat (2) @(negedge rd_clk);
    chk("wrap_rst_cnt", count, 0);
    chk("wrap_sb_empty", sb.size(), 0);
    reset   = 1'b0;
    exp_cnt = '0;
    base    = n_fire;
    for (int i = 0; i < 17; i++) begin
      pulse_in = 1'b1;
      push();
      repeat (2) @(negedge rd_clk);
      pulse_in = 1'b0;
      repeat (4) @(negedge rd_clk);
    end
    repeat (2) @(negedge rd_clk);
    chk("wrap_fires", n_fire - base, 17);
    chk("wrap_cnt", count, 1);

    // long high: stuck detector (when built in)
    pulse_in = 1'b1;
    push();
    repeat (11) @(negedge rd_clk);
    chk("stuck_pre", stuck, 0);
    @(negedge rd_clk);
`ifdef PULSE_TIMEOUT_EN
    chk("stuck_set", stuck, 1);
`else
    chk("stuck_set", stuck, 0);
`endif
    repeat (8) @(negedge rd_clk);
    pulse_in = 1'b0;
    repeat (6) @(negedge rd_clk);
`ifdef PULSE_TIMEOUT_EN
    chk("stuck_hold", stuck, 1);
`else
    chk("stuck_hold", stuck, 0);
`endif
    chk("long_busy", busy, 0);
    chk("long_cnt", count, 2);
    reset = 1'b1;
    @(negedge rd_clk);
    chk("stuck_clr", stuck, 0);
    chk("final_rst_cnt", count, 0);
    reset = 1'b0;
    repeat (4) @(negedge rd_clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
